// File: rtl/fft_twiddle_gen.sv
// Twiddle source for one radix-2 DIT FFT stage: streams W_N^k = cos - j*sin for every
// butterfly from a quarter-wave cosine ROM with symmetry mapping, two register stages, global stall.
module fft_twiddle_gen #(
  parameter int N_LOG2 = 8,
  parameter int W_BIT  = 12,
  parameter int W_MAX  = 1024
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iSTART,
  input  logic [$clog2(N_LOG2)-1:0] iSTAGE,
  input  logic                      iEN,
  output logic signed [W_BIT-1:0]   oW_RE,
  output logic signed [W_BIT-1:0]   oW_IM,
  output logic [N_LOG2-2:0]         oK,
  output logic                      oVALID,
  output logic                      oLAST,
  output logic                      oBUSY
);

  localparam int N    = 1 << N_LOG2;
  localparam int HALF = N / 2;
  localparam int QTR  = N / 4;
  localparam int S_W  = $clog2(N_LOG2);
  localparam int K_W  = N_LOG2 - 1;
  localparam int A_W  = $clog2(QTR + 1);

  localparam logic [K_W-1:0]   B_LAST    = K_W'(HALF - 1);
  localparam logic [K_W:0]     QTR_W     = (K_W + 1)'(QTR);
  localparam logic [K_W:0]     HALF_W    = (K_W + 1)'(HALF);
  localparam logic [S_W:0]     STAGE_LIM = (S_W + 1)'(N_LOG2);
  localparam logic [S_W-1:0]   STAGE_TOP = S_W'(N_LOG2 - 1);
  localparam logic [W_BIT-1:0] Q_LIMIT   = W_BIT'(W_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_r;
  logic [S_W-1:0]  stage_r;
  logic [K_W-1:0]  b_r;
  logic            flush_r;

  logic            issue_s;
  logic [K_W:0]    mask_s;
  logic [K_W:0]    k_wide_s;
  logic            hi_s;
  logic [A_W-1:0]  addr_re_s;
  logic [A_W-1:0]  addr_im_s;

  logic            p1_valid_r;
  logic            p1_last_r;
  logic [K_W-1:0]  p1_k_r;
  logic            p1_hi_r;
  logic [A_W-1:0]  p1_addr_re_r;
  logic [A_W-1:0]  p1_addr_im_r;

  logic [W_BIT-1:0] q_re_s;
  logic [W_BIT-1:0] q_im_s;
  logic [W_BIT-1:0] re_s;
  logic [W_BIT-1:0] im_s;

  // Raw table holds round(1024*cos(2*pi*m/256)) for m = 0..64; the W_MAX-1 clamp
  // keeps unit magnitude strictly inside the multiplier's range.
  function automatic logic [W_BIT-1:0] cos_q(input logic [A_W-1:0] m);
    logic [10:0]      v;
    logic [W_BIT-1:0] w;
    case (m)
      7'd0:  v = 11'd1024; 7'd1:  v = 11'd1024; 7'd2:  v = 11'd1023; 7'd3:  v = 11'd1021; 7'd4:  v = 11'd1019;
      7'd5:  v = 11'd1016; 7'd6:  v = 11'd1013; 7'd7:  v = 11'd1009; 7'd8:  v = 11'd1004; 7'd9:  v = 11'd999;
      7'd10: v = 11'd993;  7'd11: v = 11'd987;  7'd12: v = 11'd980;  7'd13: v = 11'd972;  7'd14: v = 11'd964;
      7'd15: v = 11'd955;  7'd16: v = 11'd946;  7'd17: v = 11'd936;  7'd18: v = 11'd926;  7'd19: v = 11'd915;
      7'd20: v = 11'd903;  7'd21: v = 11'd891;  7'd22: v = 11'd878;  7'd23: v = 11'd865;  7'd24: v = 11'd851;
      7'd25: v = 11'd837;  7'd26: v = 11'd822;  7'd27: v = 11'd807;  7'd28: v = 11'd792;  7'd29: v = 11'd775;
      7'd30: v = 11'd759;  7'd31: v = 11'd742;  7'd32: v = 11'd724;  7'd33: v = 11'd706;  7'd34: v = 11'd688;
      7'd35: v = 11'd669;  7'd36: v = 11'd650;  7'd37: v = 11'd630;  7'd38: v = 11'd610;  7'd39: v = 11'd590;
      7'd40: v = 11'd569;  7'd41: v = 11'd548;  7'd42: v = 11'd526;  7'd43: v = 11'd505;  7'd44: v = 11'd483;
      7'd45: v = 11'd460;  7'd46: v = 11'd438;  7'd47: v = 11'd415;  7'd48: v = 11'd392;  7'd49: v = 11'd369;
      7'd50: v = 11'd345;  7'd51: v = 11'd321;  7'd52: v = 11'd297;  7'd53: v = 11'd273;  7'd54: v = 11'd249;
      7'd55: v = 11'd224;  7'd56: v = 11'd200;  7'd57: v = 11'd175;  7'd58: v = 11'd150;  7'd59: v = 11'd125;
      7'd60: v = 11'd100;  7'd61: v = 11'd75;   7'd62: v = 11'd50;   7'd63: v = 11'd25;   7'd64: v = 11'd0;
      default: v = 11'd0;
    endcase
    w = W_BIT'(v);
    if (w > Q_LIMIT) begin
      return Q_LIMIT;
    end else begin
      return w;
    end
  endfunction

  // One extra bit for the negation; magnitudes never reach W_MAX so truncation cannot wrap.
  function automatic logic [W_BIT-1:0] negate(input logic [W_BIT-1:0] v);
    logic [W_BIT:0] wide;
    wide = -{1'b0, v};
    return W_BIT'(wide);
  endfunction

  assign issue_s = (state_r == RUN);

  // Twiddle index for the current butterfly and its ROM addresses.
  always_comb begin
    mask_s   = ((K_W + 1)'(1) << stage_r) - (K_W + 1)'(1);
    k_wide_s = ({1'b0, b_r} & mask_s) << (STAGE_TOP - stage_r);
    if (k_wide_s <= QTR_W) begin
      hi_s      = 1'b0;
      addr_re_s = A_W'(k_wide_s);
      addr_im_s = A_W'(QTR_W - k_wide_s);
    end else begin
      hi_s      = 1'b1;
      addr_re_s = A_W'(HALF_W - k_wide_s);
      addr_im_s = A_W'(k_wide_s - QTR_W);
    end
  end

  // ROM read and sign application for the second register stage.
  always_comb begin
    q_re_s = cos_q(p1_addr_re_r);
    q_im_s = cos_q(p1_addr_im_r);
    im_s   = negate(q_im_s);
    if (p1_hi_r) begin
      re_s = negate(q_re_s);
    end else begin
      re_s = q_re_s;
    end
  end

  // Run control: accept start, count butterflies, drain two cycles, drive busy.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_r <= IDLE;
      stage_r <= '0;
      b_r     <= '0;
      flush_r <= 1'b0;
      oBUSY   <= 1'b0;
    end else if (iEN) begin
      case (state_r)
        IDLE: begin
          if (iSTART) begin
            stage_r <= ({1'b0, iSTAGE} >= STAGE_LIM) ? STAGE_TOP : iSTAGE;
            b_r     <= '0;
            flush_r <= 1'b0;
            state_r <= RUN;
            oBUSY   <= 1'b1;
          end
        end
        RUN: begin
          b_r <= b_r + K_W'(1);
          if (b_r == B_LAST) begin
            state_r <= FLUSH;
            flush_r <= 1'b0;
          end
        end
        FLUSH: begin
          if (flush_r) begin
            state_r <= IDLE;
            flush_r <= 1'b0;
            oBUSY   <= 1'b0;
          end else begin
            flush_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          flush_r <= 1'b0;
          oBUSY   <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage coefficient pipeline, frozen together with the control while iEN is low.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      p1_valid_r   <= 1'b0;
      p1_last_r    <= 1'b0;
      p1_k_r       <= '0;
      p1_hi_r      <= 1'b0;
      p1_addr_re_r <= '0;
      p1_addr_im_r <= '0;
      oVALID       <= 1'b0;
      oLAST        <= 1'b0;
      oK           <= '0;
      oW_RE        <= '0;
      oW_IM        <= '0;
    end else if (iEN) begin
      p1_valid_r   <= issue_s;
      p1_last_r    <= issue_s && (b_r == B_LAST);
      p1_k_r       <= K_W'(k_wide_s);
      p1_hi_r      <= hi_s;
      p1_addr_re_r <= addr_re_s;
      p1_addr_im_r <= addr_im_s;
      oVALID       <= p1_valid_r;
      oLAST        <= p1_last_r;
      oK           <= p1_k_r;
      oW_RE        <= re_s;
      oW_IM        <= im_s;
    end
  end

endmodule
